// File: rtl/calculate_statistics_axis_stall_detector_if.sv
// Signal bundle between a kernel's AXI-Stream ports and the stall detector.
// The detector observes both streams plus control, and reports block flags and stall statistics.
interface calculate_statistics_axis_stall_detector_if #(
  parameter int CNT_W = 16
);
  // Handshake: a beat transfers on any edge where tvalid & tready are both high.
  // The detector never drives tvalid/tready; it only watches them.
  logic             in_tvalid;
  logic             in_tready;
  logic             out_tvalid;
  logic             out_tready;
  logic             inst_idle;
  logic             clear;

  logic [1:0]       axis_block_sigs;
  logic             any_block;
  logic [CNT_W-1:0] stall_cnt0;
  logic [CNT_W-1:0] stall_cnt1;
  logic [CNT_W-1:0] max_stall0;
  logic [CNT_W-1:0] max_stall1;
  logic [1:0]       dbg_state0;
  logic [1:0]       dbg_state1;

  modport slave (
    input  in_tvalid, in_tready, out_tvalid, out_tready, inst_idle, clear,
    output axis_block_sigs, any_block, stall_cnt0, stall_cnt1,
           max_stall0, max_stall1, dbg_state0, dbg_state1
  );

  modport master (
    output in_tvalid, in_tready, out_tvalid, out_tready, inst_idle, clear,
    input  axis_block_sigs, any_block, stall_cnt0, stall_cnt1,
           max_stall0, max_stall1, dbg_state0, dbg_state1
  );
endinterface

// File: rtl/calculate_statistics_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: counts consecutive stalled cycles, tracks the
// longest run, and raises a blocked flag once a run reaches STALL_THRESHOLD.
module calculate_statistics_axis_stall_detector_chan #(
  parameter int STALL_THRESHOLD = 1024,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_cond,
  input  logic             i_clear,
  output logic             o_block,
  output logic             o_block_nxt,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_max,
  output logic [1:0]       o_state
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESHOLD);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] w_max_nxt;
  logic             r_block;
  logic             w_block_nxt;
  logic             w_at_thresh;

  // Counter saturates instead of wrapping so a very long stall never looks short.
  always_comb begin
    w_cnt_nxt = '0;
    if (!i_clear && i_cond) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    end
  end

  assign w_at_thresh = (w_cnt_nxt >= THRESH);

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A threshold of 1 makes the first stalled cycle already blocking.
          if (i_cond) w_state_nxt = w_at_thresh ? ST_BLOCKED : ST_WAIT;
        end
        ST_WAIT: begin
          if (!i_cond)          w_state_nxt = ST_IDLE;
          else if (w_at_thresh) w_state_nxt = ST_BLOCKED;
        end
        ST_BLOCKED: begin
          if (!i_cond) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_max_nxt = r_max;
    if (i_clear) begin
      w_max_nxt = '0;
    end else if (w_cnt_nxt > r_max) begin
      w_max_nxt = w_cnt_nxt;
    end
  end

  assign w_block_nxt = (w_state_nxt == ST_BLOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
      r_block <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_max   <= w_max_nxt;
      r_block <= w_block_nxt;
    end
  end

  assign o_block     = r_block;
  assign o_block_nxt = w_block_nxt;
  assign o_cnt       = r_cnt;
  assign o_max       = r_max;
  assign o_state     = r_state;
endmodule

module calculate_statistics_axis_stall_detector #(
  parameter int STALL_THRESHOLD = 1024,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  calculate_statistics_axis_stall_detector_if.slave bus
);
  logic w_cond0;
  logic w_cond1;
  logic w_block0;
  logic w_block1;
  logic w_block_nxt0;
  logic w_block_nxt1;
  logic r_any;

  // Channel 0 starves on an empty input; channel 1 backs up on a full output.
  // An idle instance is not stalled, whatever its stream signals show.
  assign w_cond0 = bus.in_tready  & ~bus.in_tvalid & ~bus.inst_idle;
  assign w_cond1 = bus.out_tvalid & ~bus.out_tready & ~bus.inst_idle;

  calculate_statistics_axis_stall_detector_chan #(
    .STALL_THRESHOLD(STALL_THRESHOLD),
    .CNT_W          (CNT_W)
  ) u_chan0 (
    .clock      (clock),
    .reset      (reset),
    .i_cond     (w_cond0),
    .i_clear    (bus.clear),
    .o_block    (w_block0),
    .o_block_nxt(w_block_nxt0),
    .o_cnt      (bus.stall_cnt0),
    .o_max      (bus.max_stall0),
    .o_state    (bus.dbg_state0)
  );

  calculate_statistics_axis_stall_detector_chan #(
    .STALL_THRESHOLD(STALL_THRESHOLD),
    .CNT_W          (CNT_W)
  ) u_chan1 (
    .clock      (clock),
    .reset      (reset),
    .i_cond     (w_cond1),
    .i_clear    (bus.clear),
    .o_block    (w_block1),
    .o_block_nxt(w_block_nxt1),
    .o_cnt      (bus.stall_cnt1),
    .o_max      (bus.max_stall1),
    .o_state    (bus.dbg_state1)
  );

  // Built from next-state flags so it lands on the same edge as the per-channel flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_any <= 1'b0;
    end else begin
      r_any <= w_block_nxt0 | w_block_nxt1;
    end
  end

  assign bus.axis_block_sigs = {w_block1, w_block0};
  assign bus.any_block       = r_any;
endmodule

// File: tb/tb_calculate_statistics_axis_stall_detector.sv
// Bench for the stall detector: vector table plus a long saturation run, checked through
// an expected-value queue sampled 1 ns after each rising edge.
module tb_calculate_statistics_axis_stall_detector;
  localparam int CNT_W = 8;
  localparam int THR   = 4;
  localparam int EXP_W = 2 + 1 + 4 * CNT_W;

  // ctl = {reset, clear, inst_idle}; ch = {in_tvalid, in_tready, out_tvalid, out_tready}
  localparam logic [2:0] RUN  = 3'b000;
  localparam logic [2:0] RST  = 3'b100;
  localparam logic [2:0] CLR  = 3'b010;
  localparam logic [2:0] IDL  = 3'b001;
  localparam logic [3:0] S0N1 = 4'b0101;
  localparam logic [3:0] N0N1 = 4'b1101;
  localparam logic [3:0] N0S1 = 4'b1110;
  localparam logic [3:0] S0S1 = 4'b0110;
  localparam logic [3:0] N0H1 = 4'b1111;

  typedef struct packed {
    logic [6:0]       stim;
    logic [EXP_W-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  calculate_statistics_axis_stall_detector_if #(.CNT_W(CNT_W)) bus ();

  calculate_statistics_axis_stall_detector #(
    .STALL_THRESHOLD(THR),
    .CNT_W          (CNT_W)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---- clock / reset ----
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want finish");
    $fatal(1, "watchdog");
  end

  // ---- scoreboard ----
  logic [EXP_W-1:0] exp_q[$];
  vec_t             vecs[$];
  int               n_vec = 0;
  int               n_err = 0;

  function automatic vec_t mk(logic [2:0] ctl, logic [3:0] ch, logic [1:0] blk, logic any,
                              int c0, int c1, int m0, int m1);
    vec_t v;
    v.stim = {ctl, ch};
    v.exp  = {blk, any, CNT_W'(c0), CNT_W'(c1), CNT_W'(m0), CNT_W'(m1)};
    return v;
  endfunction

  task automatic check(input string tag, input int idx);
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    got = {bus.axis_block_sigs, bus.any_block, bus.stall_cnt0, bus.stall_cnt1,
           bus.max_stall0, bus.max_stall1};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s[%0d]: got output with no expectation queued, want one queued", tag, idx);
      return;
    end
    exp = exp_q.pop_front();
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got blk=%b any=%b c0=%0d c1=%0d m0=%0d m1=%0d, want blk=%b any=%b c0=%0d c1=%0d m0=%0d m1=%0d",
               tag, idx, got[EXP_W-1 -: 2], got[EXP_W-3], got[4*CNT_W-1 -: CNT_W],
               got[3*CNT_W-1 -: CNT_W], got[2*CNT_W-1 -: CNT_W], got[CNT_W-1:0],
               exp[EXP_W-1 -: 2], exp[EXP_W-3], exp[4*CNT_W-1 -: CNT_W],
               exp[3*CNT_W-1 -: CNT_W], exp[2*CNT_W-1 -: CNT_W], exp[CNT_W-1:0]);
    end
  endtask

  // ---- driver ----
  task automatic drive(input vec_t v, input string tag, input int idx);
    @(negedge clock);
    {reset, bus.clear, bus.inst_idle, bus.in_tvalid, bus.in_tready,
     bus.out_tvalid, bus.out_tready} = v.stim;
    exp_q.push_back(v.exp);
    @(posedge clock);
    #1;
    check(tag, idx);
  endtask

  initial begin
    bus.clear      = 1'b0;
    bus.inst_idle  = 1'b0;
    bus.in_tvalid  = 1'b1;
    bus.in_tready  = 1'b1;
    bus.out_tvalid = 1'b0;
    bus.out_tready = 1'b1;

    // Reset with channel 0 stall inputs present: reset wins.
    vecs.push_back(mk(RST, S0N1, 2'b00, 0, 0, 0, 0, 0));
    // Channel 0 starvation for 6 cycles, flag from the 4th edge.
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 1, 0, 1, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 2, 0, 2, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 3, 0, 3, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b01, 1, 4, 0, 4, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b01, 1, 5, 0, 5, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b01, 1, 6, 0, 6, 0));
    vecs.push_back(mk(RUN, N0N1, 2'b00, 0, 0, 0, 6, 0));
    // Short channel 1 stall of 3 cycles, then a completed handshake.
    vecs.push_back(mk(RUN, N0S1, 2'b00, 0, 0, 1, 6, 1));
    vecs.push_back(mk(RUN, N0S1, 2'b00, 0, 0, 2, 6, 2));
    vecs.push_back(mk(RUN, N0S1, 2'b00, 0, 0, 3, 6, 3));
    vecs.push_back(mk(RUN, N0H1, 2'b00, 0, 0, 0, 6, 3));
    // Both stalled for 5 cycles, then released one at a time.
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 1, 1, 6, 3));
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 2, 2, 6, 3));
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 3, 3, 6, 3));
    vecs.push_back(mk(RUN, S0S1, 2'b11, 1, 4, 4, 6, 4));
    vecs.push_back(mk(RUN, S0S1, 2'b11, 1, 5, 5, 6, 5));
    vecs.push_back(mk(RUN, N0S1, 2'b10, 1, 0, 6, 6, 6));
    vecs.push_back(mk(RUN, N0N1, 2'b00, 0, 0, 0, 6, 6));
    // Both blocked at count 5, then clear with stall inputs still present.
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 1, 1, 6, 6));
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 2, 2, 6, 6));
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 3, 3, 6, 6));
    vecs.push_back(mk(RUN, S0S1, 2'b11, 1, 4, 4, 6, 6));
    vecs.push_back(mk(RUN, S0S1, 2'b11, 1, 5, 5, 6, 6));
    vecs.push_back(mk(CLR, S0S1, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(RUN, S0S1, 2'b00, 0, 1, 1, 1, 1));
    vecs.push_back(mk(RUN, N0N1, 2'b00, 0, 0, 0, 1, 1));
    // Idle instance masks both stall conditions.
    vecs.push_back(mk(IDL, S0S1, 2'b00, 0, 0, 0, 1, 1));
    vecs.push_back(mk(IDL, S0S1, 2'b00, 0, 0, 0, 1, 1));
    vecs.push_back(mk(IDL, S0S1, 2'b00, 0, 0, 0, 1, 1));
    // Idle rising during WAIT returns the channel to IDLE with count 0.
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 1, 0, 1, 1));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 2, 0, 2, 1));
    vecs.push_back(mk(IDL, S0N1, 2'b00, 0, 0, 0, 2, 1));
    // Reset while channel 0 is blocked, then counting restarts from 0.
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 1, 0, 2, 1));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 2, 0, 2, 1));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 3, 0, 3, 1));
    vecs.push_back(mk(RUN, S0N1, 2'b01, 1, 4, 0, 4, 1));
    vecs.push_back(mk(RST, S0N1, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(RUN, S0N1, 2'b00, 0, 1, 0, 1, 0));
    vecs.push_back(mk(RUN, N0N1, 2'b00, 0, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], "table", i);
    end

    // Saturation: 300 stalled cycles on channel 0, count pins at 255.
    drive(mk(RST, N0N1, 2'b00, 0, 0, 0, 0, 0), "sat_rst", 0);
    for (int i = 1; i <= 300; i++) begin
      int c;
      logic hit;
      c   = (i > 255) ? 255 : i;
      hit = (i >= THR);
      drive(mk(RUN, S0N1, {1'b0, hit}, hit, c, 0, c, 0), "sat", i);
    end
    drive(mk(RUN, N0N1, 2'b00, 0, 0, 0, 255, 0), "sat_release", 0);

    // Random non-stalling traffic on channel 0 (tvalid high) never counts.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ch;
      ch = {1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
      drive(mk(RUN, ch, 2'b00, 0, 0, 0, 255, 0), "rand_nostall", i);
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calculate_statistics_axis_stall_detector.md
CALCULATE_STATISTICS_AXIS_STALL_DETECTOR -- requirements
Module: calculate_statistics_axis_stall_detector

Interface
REQ-001 Parameter: STALL_THRESHOLD, 1024, consecutive stalled cycles before a channel is declared blocked; legal range 1 to 2^CNT_W-1.
REQ-002 Parameter: CNT_W, 16, width of the stall counters and max-stall registers.
REQ-003 Port: clock  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_tvalid  input  1  TVALID of the kernel input AXI-Stream (channel 0).
REQ-006 Port: in_tready  input  1  TREADY driven by the kernel on channel 0.
REQ-007 Port: out_tvalid  input  1  TVALID driven by the kernel on its output AXI-Stream (channel 1).
REQ-008 Port: out_tready  input  1  TREADY from the downstream consumer on channel 1.
REQ-009 Port: inst_idle  input  1  kernel instance idle; when high it masks both stall conditions.
REQ-010 Port: clear  input  1  synchronous clear of counters, max registers and FSMs.
REQ-011 Port: axis_block_sigs  output  2  per-channel blocked flags; bit 0 is channel 0, bit 1 is channel 1; these feed the deadlock monitor.
REQ-012 Port: any_block  output  1  registered OR of both axis_block_sigs bits.
REQ-013 Port: stall_cnt0 / stall_cnt1  output  CNT_W each  current consecutive-stall count per channel.
REQ-014 Port: max_stall0 / max_stall1  output  CNT_W each  largest count reached per channel since the last reset or clear.

Function
REQ-015 Channel 0 stall condition: in_tready=1, in_tvalid=0 and inst_idle=0. This is the kernel blocked on an empty input.
REQ-016 Channel 1 stall condition: out_tvalid=1, out_tready=0 and inst_idle=0. This is the kernel blocked on a full output.
REQ-017 Each channel has an independent FSM with states IDLE, WAIT and BLOCKED.
REQ-018 FSM transitions on each rising edge of clock:
  - IDLE->WAIT when the condition is sampled high.
  - WAIT->IDLE when the condition is sampled low.
  - WAIT->BLOCKED when the count becomes STALL_THRESHOLD.
  - BLOCKED->IDLE when the condition is sampled low.
  - IDLE->BLOCKED directly when STALL_THRESHOLD=1.
REQ-019 Counter update on each edge:
  - Condition sampled high: stall_cntN increments.
  - Condition sampled low: stall_cntN loads 0.
  - The counter saturates at 2^CNT_W-1 and never wraps.
REQ-020 axis_block_sigs[N] is a registered output. It is 1 exactly while FSM N is in BLOCKED. It therefore rises on the edge at which the STALL_THRESHOLD-th consecutive stalled cycle is sampled, and falls on the first edge at which the condition is sampled low.
REQ-021 any_block equals the OR of the next-state values of both flags, so it is cycle-aligned with axis_block_sigs.
REQ-022 max_stallN loads stall_cntN's next value whenever that value exceeds the current max_stallN; it saturates with the counter.
REQ-023 A completed handshake (tvalid & tready) breaks the stall condition by construction. No additional handshake tracking is required.
REQ-024 clear=1 on an edge forces the following for both channels, and the stall inputs in that cycle are ignored:
  - FSMs to IDLE
  - counters to 0
  - max registers to 0
  - axis_block_sigs to 0
  - any_block to 0
REQ-025 inst_idle rising while a channel is in WAIT or BLOCKED returns that channel to IDLE with count 0 on the same edge.
REQ-026 Both channels may be BLOCKED simultaneously; the channels never interact.

Reset
REQ-027 reset=1 on an edge forces the following; reset has priority over clear and all inputs:
  - FSMs to IDLE
  - axis_block_sigs=2'b00
  - any_block=0
  - stall_cnt0/1=0
  - max_stall0/1=0
REQ-028 Reset asserted mid-stall drops any asserted block flag on that same edge. Counting restarts from 0 after reset deasserts.

Verification (bench uses STALL_THRESHOLD=4, CNT_W=8)
REQ-029 Channel 0 starvation: in_tready=1, in_tvalid=0, inst_idle=0 for 6 cycles.
  - axis_block_sigs[0] rises after the 4th sampled edge.
  - stall_cnt0 reads 1,2,3,4,5,6 on successive edges.
  - max_stall0=6.
  - Driving in_tvalid=1 clears bit 0 and stall_cnt0 to 0 on the next edge.
REQ-030 Short stall: out_tvalid=1, out_tready=0 for 3 cycles, then out_tready=1.
  - axis_block_sigs[1] never asserts.
  - max_stall1=3.
REQ-031 Both channels stalled from the same edge for 5 cycles.
  - axis_block_sigs=2'b11 and any_block=1 after the 4th edge.
  - Both flags are independently clearable by releasing each channel.
REQ-032 clear pulsed while both channels are BLOCKED with counts=5: on that edge, all counts, max registers and flags are 0.
REQ-033 Saturation: channel 0 stalled for 300 cycles. stall_cnt0 holds 255 and does not wrap to 0.
REQ-034 Idle masking and reset: inst_idle=1 with channel 0 stalled.
  - No counting occurs and no flag asserts.
  - Separately, reset asserted while axis_block_sigs=2'b01 yields 2'b00 and all counters 0 on that edge.
